// File: rtl/perf_snapshot_writer.sv
// rtl/perf_snapshot_writer.sv - captures perf counters on trigger edge and writes them as 64-bit beats
// Define PERF_SNAPSHOT_TIMESTAMP_EN to prepend a free-running cycle-count word after word0.
module perf_snapshot_writer #(
    parameter int NumCounters = 6,
    parameter int AddrWidth   = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      trig_i,
    input  logic [NumCounters*64-1:0] counters_i,
    input  logic [AddrWidth-1:0]      base_addr_i,
    output logic                      wr_req_o,
    output logic [AddrWidth-1:0]      wr_addr_o,
    output logic [63:0]               wr_data_o,
    input  logic                      wr_gnt_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [15:0]               overrun_cnt_o
);

`ifdef PERF_SNAPSHOT_TIMESTAMP_EN
    localparam int TsWords = 1;
`else
    localparam int TsWords = 0;
`endif
    localparam int NWords = 1 + TsWords + NumCounters;
    localparam int BeatW  = $clog2(NWords);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 trig_q;
    logic [BeatW-1:0]     beat_q;
    logic [AddrWidth-1:0] base_q;
    logic [63:0]          word0_q;
    logic [31:0]          seq_q;
    logic [15:0]          overrun_q;
    logic [63:0]          snap_q [NumCounters];
    logic [63:0]          word;

    logic trig_edge, base_ok, accept, overrun_ev, beat_gnt, last_beat;
    logic unused_base_bits;

    assign unused_base_bits = ^base_addr_i[2:0];

    // A trigger with an all-zero base (ignoring byte offset) means the buffer is disabled.
    assign trig_edge  = trig_i & ~trig_q;
    assign base_ok    = |base_addr_i[AddrWidth-1:3];
    assign accept     = trig_edge & base_ok & (state_q == IDLE);
    assign overrun_ev = trig_edge & base_ok & (state_q != IDLE);
    assign beat_gnt   = (state_q == WRITE) & wr_gnt_i;
    assign last_beat  = (beat_q == BeatW'(NWords - 1));

    always_ff @(posedge clk_i) begin : state_reg
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WRITE;
            WRITE:   if (wr_gnt_i && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        wr_req_o  = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            WRITE: begin
                wr_req_o  = 1'b1;
                wr_addr_o = base_q + (AddrWidth'(beat_q) << 3);
                wr_data_o = word;
                busy_o    = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin : control_regs
        if (rst_i) begin
            trig_q    <= 1'b0;
            beat_q    <= '0;
            base_q    <= '0;
            word0_q   <= '0;
            seq_q     <= '0;
            overrun_q <= '0;
        end else begin
            trig_q <= trig_i;
            if (accept) begin
                beat_q  <= '0;
                base_q  <= {base_addr_i[AddrWidth-1:3], 3'b000};
                word0_q <= {16'(NumCounters), overrun_q, seq_q};
            end else if (beat_gnt) begin
                beat_q <= beat_q + BeatW'(1);
            end
            if (state_q == DONE) begin
                seq_q <= seq_q + 32'd1;
            end
            if (overrun_ev && (overrun_q != 16'hFFFF)) begin
                overrun_q <= overrun_q + 16'd1;
            end
        end
    end

    // Snapshot payload needs no reset: it is only read after a capture loads it.
    always_ff @(posedge clk_i) begin : snapshot_regs
        if (accept) begin
            for (int k = 0; k < NumCounters; k++) begin
                snap_q[k] <= counters_i[64*k +: 64];
            end
        end
    end

`ifdef PERF_SNAPSHOT_TIMESTAMP_EN
    logic [63:0] cycle_q;
    logic [63:0] ts_snap_q;

    always_ff @(posedge clk_i) begin : cycle_counter
        if (rst_i) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin : ts_snapshot
        if (accept) begin
            ts_snap_q <= cycle_q;
        end
    end
`endif

    always_comb begin : word_mux
        word = word0_q;
`ifdef PERF_SNAPSHOT_TIMESTAMP_EN
        if (beat_q == BeatW'(1)) word = ts_snap_q;
`endif
        for (int k = 0; k < NumCounters; k++) begin
            if (beat_q == BeatW'(k + 1 + TsWords)) word = snap_q[k];
        end
    end

    assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_perf_snapshot_writer.sv
// tb/tb_perf_snapshot_writer.sv - directed scoreboard bench for perf_snapshot_writer
module tb_perf_snapshot_writer;

    localparam int NC = 6;
    localparam int AW = 64;
    localparam int NW = NC + 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             trig_i;
    logic [NC*64-1:0] counters_i;
    logic [AW-1:0]    base_addr_i;
    logic             wr_req_o;
    logic [AW-1:0]    wr_addr_o;
    logic [63:0]      wr_data_o;
    logic             wr_gnt_i;
    logic             busy_o;
    logic             done_o;
    logic [15:0]      overrun_cnt_o;

    perf_snapshot_writer #(.NumCounters(NC), .AddrWidth(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .trig_i       (trig_i),
        .counters_i   (counters_i),
        .base_addr_i  (base_addr_i),
        .wr_req_o     (wr_req_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .wr_gnt_i     (wr_gnt_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overrun_cnt_o(overrun_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          last_gnt_cyc = -10;
    logic [31:0] seq_m = '0;
    logic [15:0] ovr_m = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        beat_t e;
        if (wr_req_o === 1'b1 && wr_gnt_i === 1'b1 && rst_i === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_queue_depth", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", wr_addr_o, e.addr);
                check("wr_data", wr_data_o, e.data);
            end
            last_gnt_cyc = cyc;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            check("done_latency", 64'(cyc), 64'(last_gnt_cyc + 1));
            check("done_queue_empty", 64'(exp_q.size()), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_counters(input logic [63:0] off);
        for (int k = 0; k < NC; k++) counters_i[64*k +: 64] = off + 64'(k);
    endtask

    task automatic push_snapshot(input logic [63:0] base);
        beat_t       e;
        logic [63:0] b;
        b = {base[63:3], 3'b000};
        for (int i = 0; i < NW; i++) begin
            e.addr = b + 64'(8 * i);
            e.data = (i == 0) ? {16'(NC), ovr_m, seq_m} : counters_i[64*(i-1) +: 64];
            exp_q.push_back(e);
        end
    endtask

    task automatic fire();
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(done_cnt), 64'(target));
    endtask

    task automatic wait_addr(input logic [63:0] a, input string tag);
        int n = 0;
        while (!(wr_req_o === 1'b1 && wr_addr_o === a) && n < 50) begin
            tick();
            n++;
        end
        check(tag, (wr_req_o === 1'b1) ? wr_addr_o : ~a, a);
    endtask

    initial begin : stimulus
        logic saw_req;
        rst_i       = 1'b1;
        trig_i      = 1'b0;
        wr_gnt_i    = 1'b1;
        base_addr_i = '0;
        set_counters(64'h100);
        repeat (3) tick();
        check("reset_wr_req", 64'(wr_req_o), 64'd0);
        check("reset_wr_addr", wr_addr_o, 64'd0);
        check("reset_wr_data", wr_data_o, 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_overrun", 64'(overrun_cnt_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Basic snapshot, gnt always high
        base_addr_i = 64'h8000_0000;
        set_counters(64'h100);
        push_snapshot(base_addr_i);
        trig_i = 1'b1;
        @(negedge clk);
        check("req_before_capture", 64'(wr_req_o), 64'd0);
        @(negedge clk);
        check("req_latency", 64'(wr_req_o), 64'd1);
        check("busy_after_capture", 64'(busy_o), 64'd1);
        tick();
        trig_i = 1'b0;
        wait_done(1, "snap1_done");
        seq_m = seq_m + 1;
        check("done_single_cycle", 64'(done_o), 64'd0);
        check("busy_after_done", 64'(busy_o), 64'd0);

        // Grant stall on beat 2 with live counters changing
        set_counters(64'h200);
        push_snapshot(base_addr_i);
        fire();
        wait_addr(base_addr_i + 64'h10, "stall_reach_beat2");
        wr_gnt_i = 1'b0;
        set_counters(64'h900);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr_stable", wr_addr_o, 64'h8000_0010);
            check("stall_data_stable", wr_data_o, 64'h201);
        end
        wr_gnt_i = 1'b1;
        wait_done(2, "snap2_done");
        seq_m = seq_m + 1;

        // Overrun during beat 3
        set_counters(64'h300);
        push_snapshot(base_addr_i);
        fire();
        wait_addr(base_addr_i + 64'h18, "ovr_reach_beat3");
        fire();
        ovr_m = ovr_m + 1;
        check("overrun_count", 64'(overrun_cnt_o), 64'(ovr_m));
        wait_done(3, "snap3_done");
        seq_m = seq_m + 1;

        // Snapshot after overrun; base changes mid-flight have no effect
        set_counters(64'h400);
        push_snapshot(base_addr_i);
        fire();
        base_addr_i = 64'h1234_0000;
        wait_done(4, "snap4_done");
        seq_m = seq_m + 1;

        // Disabled base
        base_addr_i = 64'h7;
        fire();
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wr_req_o) saw_req = 1'b1;
        end
        check("disabled_no_req", 64'(saw_req), 64'd0);
        check("disabled_overrun", 64'(overrun_cnt_o), 64'(ovr_m));

        // Address wrap, unaligned base bits dropped
        base_addr_i = 64'hFFFF_FFFF_FFFF_FFF3;
        set_counters(64'h600);
        push_snapshot(base_addr_i);
        fire();
        wait_done(5, "wrap_done");
        seq_m = seq_m + 1;

        // Reset mid-snapshot at beat 4
        base_addr_i = 64'h8000_0000;
        set_counters(64'h700);
        push_snapshot(base_addr_i);
        fire();
        wait_addr(base_addr_i + 64'h20, "rst_reach_beat4");
        rst_i = 1'b1;
        tick();
        check("rst_req_drop", 64'(wr_req_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_overrun", 64'(overrun_cnt_o), 64'd0);
        check("rst_abandoned_beats", 64'(exp_q.size()), 64'd3);
        exp_q.delete();
        rst_i = 1'b0;
        seq_m = '0;
        ovr_m = '0;
        repeat (10) tick();
        check("rst_no_done", 64'(done_cnt), 64'd5);

        // Post-reset snapshot with overrun, then one more
        set_counters(64'h800);
        push_snapshot(base_addr_i);
        fire();
        wait_addr(base_addr_i + 64'h18, "post_rst_beat3");
        fire();
        ovr_m = ovr_m + 1;
        wait_done(6, "snap6_done");
        seq_m = seq_m + 1;

        set_counters(64'hA00);
        push_snapshot(base_addr_i);
        fire();
        wait_done(7, "snap7_done");
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
